// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache: 4-word lines, zero-latency hits,
// block refill from instruction memory over a read/busywait handshake.
`timescale 1ns/1ps
module icache #(
  parameter int MEM_ADDR_BITS = 10,
  parameter int INDEX_BITS    = 3
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [31:0]              PC,
  output logic [31:0]              INSTRUCTION,
  output logic                     BUSYWAIT,
  output logic                     MEM_READ,
  output logic [MEM_ADDR_BITS-5:0] MEM_ADDRESS,
  input  logic [127:0]             MEM_READDATA,
  input  logic                     MEM_BUSYWAIT
);
  localparam int TAG_BITS = MEM_ADDR_BITS - 4 - INDEX_BITS;
  localparam int LINES    = 1 << INDEX_BITS;

  typedef enum logic [1:0] {S_IDLE, S_MEM_READ, S_UPDATE} state_t;

  state_t                   state;
  logic [LINES-1:0]         valid;
  logic [TAG_BITS-1:0]      tags  [LINES];
  logic [127:0]             lines [LINES];
  logic [MEM_ADDR_BITS-5:0] miss_addr;
  logic [127:0]             fill_data;

  logic [INDEX_BITS-1:0]    pc_index;
  logic [TAG_BITS-1:0]      pc_tag;
  logic [INDEX_BITS-1:0]    miss_index;
  logic [TAG_BITS-1:0]      miss_tag;
  logic [127:0]             line_sel;
  logic [31:0]              word_sel;
  logic                     hit;
  logic                     unused_pc;

  assign pc_index   = PC[4+INDEX_BITS-1:4];
  assign pc_tag     = PC[MEM_ADDR_BITS-1:4+INDEX_BITS];
  assign miss_index = miss_addr[INDEX_BITS-1:0];
  assign miss_tag   = miss_addr[MEM_ADDR_BITS-5:INDEX_BITS];
  assign unused_pc  = ^{PC[31:MEM_ADDR_BITS], PC[1:0]};

  assign hit      = valid[pc_index] && (tags[pc_index] == pc_tag);
  assign line_sel = lines[pc_index];
  assign word_sel = line_sel[{PC[3:2], 5'b0} +: 32];

  // BUSYWAIT is forced low while reset is held even though every line is invalid.
  assign BUSYWAIT    = RESET && ((state != S_IDLE) || !hit);
  assign INSTRUCTION = ((state == S_IDLE) && hit) ? word_sel : 32'h0;
  assign MEM_READ    = (state == S_MEM_READ);
  assign MEM_ADDRESS = miss_addr;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= S_IDLE;
      valid     <= '0;
      miss_addr <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!hit) begin
            miss_addr <= PC[MEM_ADDR_BITS-1:4];
            state     <= S_MEM_READ;
          end
        end
        S_MEM_READ: begin
          if (!MEM_BUSYWAIT) state <= S_UPDATE;
        end
        S_UPDATE: begin
          valid[miss_index] <= 1'b1;
          state             <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Payload storage carries no reset; the valid bits alone qualify it.
  always_ff @(posedge CLK) begin
    if (state == S_MEM_READ && !MEM_BUSYWAIT) fill_data <= MEM_READDATA;
    if (state == S_UPDATE) begin
      lines[miss_index] <= fill_data;
      tags[miss_index]  <= miss_tag;
    end
  end
endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: hit vectors from a table plus hand-written
// refill, conflict, PC-change and mid-miss reset sequences.
`timescale 1ns/1ps
module tb_icache;
  logic         CLK;
  logic         RESET;
  logic [31:0]  PC;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic [5:0]   MEM_ADDRESS;
  logic [127:0] mem_data;
  logic         mem_busy;

  int checks;
  int failures;

  typedef struct {
    logic [31:0] pc;
    logic        busy;
    logic [31:0] instr;
  } vec_t;
  vec_t vecs[9];

  icache dut (
    .CLK(CLK), .RESET(RESET), .PC(PC), .INSTRUCTION(INSTRUCTION),
    .BUSYWAIT(BUSYWAIT), .MEM_READ(MEM_READ), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_READDATA(mem_data), .MEM_BUSYWAIT(mem_busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory model: each word holds its own byte address.
  function automatic logic [127:0] blk(input logic [5:0] a);
    logic [127:0] b;
    for (int w = 0; w < 4; w++) b[w*32 +: 32] = {22'b0, a, 2'(w), 2'b0};
    return b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Called at a negedge. Drives a miss on pc, holds MEM_BUSYWAIT for lat
  // posedges of the read, and switches PC to pc_mid once the read has started.
  task automatic miss_fill(input logic [31:0] pc, input int lat, input logic [31:0] pc_mid);
    logic [5:0] a;
    logic       same;
    a    = pc[9:4];
    same = (pc[9:4] == pc_mid[9:4]);
    PC = pc;
    mem_busy = 1'b1;
    mem_data = {$urandom(), $urandom(), $urandom(), $urandom()};
    #1;
    check("miss_busywait", 32'(BUSYWAIT), 32'd1);
    check("miss_no_read_yet", 32'(MEM_READ), 32'd0);
    check("miss_instr_zero", INSTRUCTION, 32'h0);
    for (int e = 0; e <= lat; e++) begin
      @(negedge CLK);
      check("read_active", 32'(MEM_READ), 32'd1);
      check("read_address", 32'(MEM_ADDRESS), 32'(a));
      check("read_busywait", 32'(BUSYWAIT), 32'd1);
      if (e == 0) PC = pc_mid;
      if (e < lat) begin
        mem_busy = 1'b1;
        mem_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      end else begin
        mem_busy = 1'b0;
        mem_data = blk(a);
      end
    end
    @(negedge CLK);
    check("update_busywait", 32'(BUSYWAIT), 32'd1);
    check("update_no_read", 32'(MEM_READ), 32'd0);
    mem_busy = 1'b1;
    mem_data = {$urandom(), $urandom(), $urandom(), $urandom()};
    @(negedge CLK);
    #1;
    check("done_busywait", 32'(BUSYWAIT), same ? 32'd0 : 32'd1);
    check("done_no_read", 32'(MEM_READ), 32'd0);
    if (same) check("done_instr", INSTRUCTION, {22'b0, pc_mid[9:2], 2'b0});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    RESET    = 1'b0;
    PC       = 32'h0;
    mem_busy = 1'b1;
    mem_data = '0;

    vecs[0] = '{pc: 32'h004,      busy: 1'b0, instr: 32'h4};
    vecs[1] = '{pc: 32'h008,      busy: 1'b0, instr: 32'h8};
    vecs[2] = '{pc: 32'h00C,      busy: 1'b0, instr: 32'hC};
    vecs[3] = '{pc: 32'h006,      busy: 1'b0, instr: 32'h4};
    vecs[4] = '{pc: 32'h404,      busy: 1'b0, instr: 32'h4};
    vecs[5] = '{pc: 32'hFFFFFC0C, busy: 1'b0, instr: 32'hC};
    vecs[6] = '{pc: 32'h010,      busy: 1'b1, instr: 32'h0};
    vecs[7] = '{pc: 32'h080,      busy: 1'b1, instr: 32'h0};
    vecs[8] = '{pc: 32'h000,      busy: 1'b0, instr: 32'h0};

    // Reset held across clock edges.
    repeat (3) @(negedge CLK);
    #1;
    check("rst_busywait", 32'(BUSYWAIT), 32'd0);
    check("rst_mem_read", 32'(MEM_READ), 32'd0);
    check("rst_address", 32'(MEM_ADDRESS), 32'd0);
    check("rst_instr", INSTRUCTION, 32'h0);

    // First fetch after release misses; 5 busy cycles.
    @(negedge CLK);
    RESET = 1'b1;
    miss_fill(32'h000, 5, 32'h000);

    // Combinational hit/miss lookups; PC returns to a hit before each edge.
    for (int i = 0; i < 9; i++) begin
      @(negedge CLK);
      PC = vecs[i].pc;
      #1;
      check("vec_busywait", 32'(BUSYWAIT), 32'(vecs[i].busy));
      check("vec_instr", INSTRUCTION, vecs[i].instr);
      check("vec_no_read", 32'(MEM_READ), 32'd0);
      PC = 32'h000;
    end

    // Conflict miss on index 0, then the evicted block misses again.
    @(negedge CLK);
    miss_fill(32'h080, 0, 32'h080);
    @(negedge CLK);
    miss_fill(32'h000, 2, 32'h000);

    // PC moves during a refill; the latched block completes, then 0x3F0 misses.
    @(negedge CLK);
    miss_fill(32'h010, 3, 32'h3F0);
    miss_fill(32'h3F0, 1, 32'h3F0);

    @(negedge CLK);
    PC = 32'h004;
    #1;
    check("hit_before_rst", INSTRUCTION, 32'h4);
    check("hit_before_rst_busy", 32'(BUSYWAIT), 32'd0);

    // Reset asserted during MEM_READ aborts without a clock edge.
    @(negedge CLK);
    PC = 32'h020;
    mem_busy = 1'b1;
    @(negedge CLK);
    check("pre_rst_read", 32'(MEM_READ), 32'd1);
    #2;
    RESET = 1'b0;
    #1;
    check("abort_mem_read", 32'(MEM_READ), 32'd0);
    check("abort_busywait", 32'(BUSYWAIT), 32'd0);
    check("abort_address", 32'(MEM_ADDRESS), 32'd0);
    @(negedge CLK);
    check("abort_held_read", 32'(MEM_READ), 32'd0);
    RESET = 1'b1;
    miss_fill(32'h004, 1, 32'h004);

    @(negedge CLK);
    PC = 32'h3F0;
    #1;
    check("post_rst_line7_miss", 32'(BUSYWAIT), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
